// File: rtl/gray_conv_arbiter_if.sv
// Request/result bundle for the shared binary<->Gray converter.
// master drives requests and out_ready; slave is the arbiter side.
interface gray_conv_arbiter_if #(
  parameter int WIDTH = 4,
  parameter int NREQ  = 4
);
  localparam int IDW = $clog2(NREQ);

  logic [NREQ-1:0]       req_valid;
  logic [NREQ*WIDTH-1:0] req_data;
  logic [NREQ-1:0]       req_mode;
  logic [NREQ-1:0]       req_ready;
  logic                  out_valid;
  logic [WIDTH-1:0]      out_data;
  logic [WIDTH-1:0]      out_src;
  logic                  out_mode;
  logic [IDW-1:0]        out_id;
  logic                  out_ready;

  modport master (
    output req_valid, req_data, req_mode, out_ready,
    input  req_ready, out_valid, out_data, out_src, out_mode, out_id
  );

  modport slave (
    input  req_valid, req_data, req_mode, out_ready,
    output req_ready, out_valid, out_data, out_src, out_mode, out_id
  );
endinterface

// File: rtl/gray_conv_arbiter.sv
// Round-robin arbiter sharing one binary<->Gray converter among NREQ requesters.
// Result is registered and held until the consumer takes it.
module gray_conv_arbiter #(
  parameter int WIDTH = 4,
  parameter int NREQ  = 4
) (
  input logic                clk,
  input logic                rst,
  gray_conv_arbiter_if.slave bus
);
  localparam int IDW = $clog2(NREQ);

  // state | meaning
  // IDLE  | arbitrating; grant is combinational on req_ready
  // BUSY  | result held on out_*, waiting for out_ready
  typedef enum logic {IDLE, BUSY} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [IDW-1:0]   r_ptr;
  logic             r_valid;
  logic [WIDTH-1:0] r_data;
  logic [WIDTH-1:0] r_src;
  logic             r_mode;
  logic [IDW-1:0]   r_id;

  logic             w_found;
  logic [IDW-1:0]   w_idx;
  logic [IDW-1:0]   w_gnt;
  logic [NREQ-1:0]  w_req_ready;
  logic [WIDTH-1:0] w_sel_data;
  logic             w_sel_mode;
  logic [WIDTH-1:0] w_conv;
  logic [WIDTH-1:0] w_data_arr [NREQ];

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_slice
    assign w_data_arr[gi] = bus.req_data[gi*WIDTH +: WIDTH];
  end

  function automatic logic [WIDTH-1:0] to_gray(input logic [WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [WIDTH-1:0] to_bin(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b[WIDTH-1] = g[WIDTH-1];
    for (int i = WIDTH-2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // Search starts at r_ptr so the last served requester ends up last in line.
  always_comb begin
    w_found    = 1'b0;
    w_idx      = '0;
    w_gnt      = '0;
    w_sel_data = '0;
    w_sel_mode = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      w_idx = IDW'((int'(r_ptr) + k) % NREQ);
      if (!w_found && bus.req_valid[w_idx]) begin
        w_found    = 1'b1;
        w_gnt      = w_idx;
        w_sel_data = w_data_arr[w_idx];
        w_sel_mode = bus.req_mode[w_idx];
      end
    end
    w_conv = w_sel_mode ? to_bin(w_sel_data) : to_gray(w_sel_data);
  end

  always_comb begin
    w_state_nxt = r_state;
    w_req_ready = '0;
    case (r_state)
      IDLE: begin
        if (w_found) begin
          w_req_ready[w_gnt] = 1'b1;
          w_state_nxt        = BUSY;
        end
      end
      BUSY: begin
        if (bus.out_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_valid <= 1'b0;
      r_data  <= '0;
      r_src   <= '0;
      r_mode  <= 1'b0;
      r_id    <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == IDLE && w_found) begin
        r_valid <= 1'b1;
        r_data  <= w_conv;
        r_src   <= w_sel_data;
        r_mode  <= w_sel_mode;
        r_id    <= w_gnt;
      end else if (r_state == BUSY && bus.out_ready) begin
        r_valid <= 1'b0;
        r_ptr   <= (r_id == IDW'(NREQ-1)) ? '0 : r_id + 1'b1;
      end
    end
  end

  assign bus.req_ready = w_req_ready;
  assign bus.out_valid = r_valid;
  assign bus.out_data  = r_data;
  assign bus.out_src   = r_src;
  assign bus.out_mode  = r_mode;
  assign bus.out_id    = r_id;
endmodule
